// File: rtl/des_round_stage.sv
// One pipelined DES Feistel round: stage 1 = E(R) xor K, stage 2 = S-boxes, P, xor L, half swap.
// Latency 2 cycles from input handshake to out_valid; throughput 1 block per cycle.
// Valid/ready back-pressure; in_ready is the only combinational path (from out_ready).
module des_round_stage #(
  parameter int TAG_W   = 4,  // sideband width, 1 or more
  parameter int NO_SWAP = 0   // 1 for the final round: halves are not swapped
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [0:31]      in_l,
  input  logic [0:31]      in_r,
  input  logic [0:47]      in_key,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [0:31]      out_l,
  output logic [0:31]      out_r,
  output logic [TAG_W-1:0] out_tag
);

  // P permutation, 0-based source positions (DES table minus one), index 0 = DES bit 1.
  localparam logic [0:31][4:0] P_TAB = {
    5'd15, 5'd6,  5'd19, 5'd20, 5'd28, 5'd11, 5'd27, 5'd16,
    5'd0,  5'd14, 5'd22, 5'd25, 5'd4,  5'd17, 5'd30, 5'd9,
    5'd1,  5'd7,  5'd23, 5'd13, 5'd31, 5'd26, 5'd2,  5'd8,
    5'd18, 5'd12, 5'd29, 5'd5,  5'd21, 5'd10, 5'd3,  5'd24
  };

  // S1..S8, each 4 rows x 16 columns, row-major, first entry in the leftmost nibble.
  localparam logic [0:7][0:63][3:0] S_TAB = {
    256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D,
    256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
    256'hA09E63F51DC7B428D709346A285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
    256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
    256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
    256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
    256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
    256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B
  };

  logic [0:47]      e_r;       // E(in_r)
  logic             s1_valid;
  logic [0:47]      s1_x;      // E(R) xor K
  logic [0:31]      s1_l;
  logic [0:31]      s1_r;
  logic [TAG_W-1:0] s1_tag;
  logic [0:31]      sbox_out;
  logic [0:31]      f_out;
  logic [0:31]      mix;
  logic [0:31]      nxt_l;
  logic [0:31]      nxt_r;
  logic             s2_load;

  // E expansion: group j takes R bits 4j-1 .. 4j+4 (0-based), wrapping around the word.
  for (genvar j = 0; j < 8; j++) begin : g_exp
    for (genvar k = 0; k < 6; k++) begin : g_bit
      assign e_r[6*j+k] = in_r[(4*j+k+31) % 32];
    end
  end

  // S-box k: row = outer bits (0,5), column = inner bits (1..4).
  for (genvar k = 0; k < 8; k++) begin : g_sbox
    assign sbox_out[4*k +: 4] = S_TAB[k][{s1_x[6*k], s1_x[6*k+5], s1_x[6*k+1 +: 4]}];
  end

  for (genvar i = 0; i < 32; i++) begin : g_perm
    assign f_out[i] = sbox_out[P_TAB[i]];
  end

  // Handshake control and the new halves of the round.
  always_comb begin
    s2_load  = s1_valid && (!out_valid || out_ready);
    in_ready = !s1_valid || s2_load;
    mix      = s1_l ^ f_out;
    nxt_l    = s1_r;
    nxt_r    = mix;
    if (NO_SWAP != 0) begin
      nxt_l = mix;
      nxt_r = s1_r;
    end
  end

  // Stage-1 valid: refreshed whenever the stage can move, so it clears once drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
    end
  end

  // Stage-1 data: loads only on an accepted block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_x   <= '0;
      s1_l   <= '0;
      s1_r   <= '0;
      s1_tag <= '0;
    end else if (in_valid && in_ready) begin
      s1_x   <= e_r ^ in_key;
      s1_l   <= in_l;
      s1_r   <= in_r;
      s1_tag <= in_tag;
    end
  end

  // Output register: loads from stage 1, holds while stalled, empties on a drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_l     <= '0;
      out_r     <= '0;
      out_tag   <= '0;
    end else if (s2_load) begin
      out_valid <= 1'b1;
      out_l     <= nxt_l;
      out_r     <= nxt_r;
      out_tag   <= s1_tag;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_des_round_stage.sv
// Testbench for des_round_stage: scoreboard against a software DES round.
// Two instances (swap / no-swap) share all inputs and run in lockstep.
// Covers reset, known answer, back-to-back, back-pressure, async reset, random traffic.
module tb_des_round_stage;

  typedef struct {
    logic [31:0] l;
    logic [31:0] r;
    logic [31:0] nl;
    logic [31:0] nr;
    logic [3:0]  tag;
    int          t0;
    bit          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_l = '0;
  logic [31:0] in_r = '0;
  logic [47:0] in_key = '0;
  logic [3:0]  in_tag = '0;
  logic        in_ready, out_valid;
  logic [31:0] out_l, out_r;
  logic [3:0]  out_tag;
  logic        n_in_ready, n_out_valid;
  logic [31:0] n_out_l, n_out_r;
  logic [3:0]  n_out_tag;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   n_out = 0;
  int   acc_cnt = 0;
  int   vld_run = 0;
  int   vld_max = 0;
  bit   rnd_done = 0;

  int e_t[48] = '{32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
                  16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
  int p_t[32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                  2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
  int s_t[8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
  };

  des_round_stage #(.TAG_W(4), .NO_SWAP(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_l(in_l), .in_r(in_r), .in_key(in_key), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_l(out_l), .out_r(out_r), .out_tag(out_tag)
  );

  des_round_stage #(.TAG_W(4), .NO_SWAP(1)) dut_ns (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_in_ready),
    .in_l(in_l), .in_r(in_r), .in_key(in_key), .in_tag(in_tag),
    .out_valid(n_out_valid), .out_ready(out_ready),
    .out_l(n_out_l), .out_r(n_out_r), .out_tag(n_out_tag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference round; plain [31:0] vectors, DES bit n lives at [32-n].
  function automatic logic [63:0] des_round(input logic [31:0] l, input logic [31:0] r,
                                            input logic [47:0] k, input bit nsw);
    logic [47:0] x;
    logic [31:0] sout, f;
    logic [5:0]  c;
    int          row, col;
    for (int i = 0; i < 48; i++) x[47-i] = r[32-e_t[i]];
    x = x ^ k;
    for (int b = 0; b < 8; b++) begin
      c = x[47-6*b -: 6];
      row = {c[5], c[0]};
      col = c[4:1];
      sout[31-4*b -: 4] = 4'(s_t[b][row*16+col]);
    end
    for (int i = 0; i < 32; i++) f[31-i] = sout[32-p_t[i]];
    if (nsw) return {l ^ f, r};
    return {r, l ^ f};
  endfunction

  // Output monitor: pops the scoreboard on every output handshake.
  always @(negedge clk) begin
    if (rst) begin
      vld_run = 0;
    end else begin
      if (out_valid) begin
        vld_run++;
        if (vld_run > vld_max) vld_max = vld_run;
      end else begin
        vld_run = 0;
      end
      if (out_valid && out_ready) begin
        check("sb_nonempty", 64'(sbq.size() != 0), 1);
        if (sbq.size() != 0) begin
          mon_e = sbq.pop_front();
          n_out++;
          check("out_l", out_l, mon_e.l);
          check("out_r", out_r, mon_e.r);
          check("out_tag", out_tag, mon_e.tag);
          check("ns_out_valid", n_out_valid, 1);
          check("ns_out_l", n_out_l, mon_e.nl);
          check("ns_out_r", n_out_r, mon_e.nr);
          if (mon_e.lat) check("latency", cyc - mon_e.t0, 2);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer one block; push its expected result when the handshake happens. Call after posedge+1.
  task automatic send(input logic [31:0] l, input logic [31:0] r, input logic [47:0] k,
                      input logic [3:0] tag, input bit lat, input bit kat);
    exp_t        e;
    logic [63:0] m0, m1;
    int          w;
    bit          done;
    in_l = l; in_r = r; in_key = k; in_tag = tag; in_valid = 1'b1;
    m0 = des_round(l, r, k, 1'b0);
    m1 = des_round(l, r, k, 1'b1);
    e.l = m0[63:32]; e.r = m0[31:0]; e.nl = m1[63:32]; e.nr = m1[31:0];
    if (kat) begin
      e.l = 32'hF0AAF0AA; e.r = 32'hEF4A6544; e.nl = 32'hEF4A6544; e.nr = 32'hF0AAF0AA;
    end
    e.tag = tag; e.lat = lat;
    w = 0; done = 0;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        e.t0 = cyc;
        sbq.push_back(e);
        acc_cnt++;
        done = 1;
      end else if (++w > 200) begin
        check("send_ready", in_ready, 1);
        done = 1;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sbq.size() != 0 && w < 300) begin
      step(1);
      w++;
    end
    step(2);
    check("drain_empty", sbq.size(), 0);
  endtask

  function automatic logic [47:0] rkey();
    return {16'($urandom), $urandom};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    logic [31:0] hl, hr;
    logic [3:0]  ht;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    step(3);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_l", out_l, 0);
    check("rst_out_r", out_r, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_ns_out_valid", n_out_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    step(1);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid_rel", out_valid, 0);

    // Known answer
    send(32'hCC00CCFF, 32'hF0AAF0AA, 48'h1B02EFFC7072, 4'h5, 1, 1);
    drain();

    // Back-to-back, tags 0..7
    vld_max = 0;
    n0 = n_out;
    for (int t = 0; t < 8; t++) send($urandom, $urandom, rkey(), 4'(t), 1, 0);
    drain();
    check("b2b_vld_run", vld_max, 8);
    check("b2b_count", n_out - n0, 8);

    // Back-pressure: out_ready low for 5 cycles with 4 blocks offered
    n0 = n_out;
    acc_cnt = 0;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send($urandom, $urandom, rkey(), 4'(8 + i), 0, 0);
      end
      begin
        repeat (3) @(negedge clk);
        check("bp_out_valid", out_valid, 1);
        hl = out_l; hr = out_r; ht = out_tag;
        repeat (2) @(negedge clk);
        check("bp_accepts", acc_cnt, 2);
        check("bp_in_ready", in_ready, 0);
        check("bp_hold_l", out_l, hl);
        check("bp_hold_r", out_r, hr);
        check("bp_hold_tag", out_tag, ht);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_count", n_out - n0, 4);

    // Asynchronous reset with two blocks in flight
    send($urandom, $urandom, rkey(), 4'hA, 0, 0);
    send($urandom, $urandom, rkey(), 4'hB, 0, 0);
    #2;
    check("pre_rst_out_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out_l", out_l, 0);
    check("arst_out_r", out_r, 0);
    check("arst_ns_out_valid", n_out_valid, 0);
    sbq.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(1);
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);
    send(32'h01234567, 32'h89ABCDEF, 48'h0F1E2D3C4B5A, 4'hC, 1, 0);
    drain();

    // Random traffic
    n0 = n_out;
    rnd_done = 0;
    fork
      begin
        for (int i = 0; i < 2000; i++) begin
          if ($urandom_range(0, 3) == 0) step(1);
          send($urandom, $urandom, rkey(), 4'($urandom), 0, 0);
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();
    check("rnd_count", n_out - n0, 2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
